// File: rtl/onehot_scan_decoder_pkg.sv
// Shared constants for the one-hot scan decoder: mode/direction encodings
// and the prescaler counter width helper.
package onehot_scan_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // A 1-cycle step still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int step_cyc);
    return (step_cyc > 1) ? $clog2(step_cyc) : 1;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_step_tick.sv
// STEP_CYC prescaler: produces a one-cycle tick every STEP_CYC enabled cycles.
// clr holds the count at zero so a scan starts with a full step.
module onehot_step_tick
  import onehot_scan_pkg::*;
#(
  parameter int STEP_CYC = 4
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = cnt_width(STEP_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign tick = en && !clr && (cnt_q == CNT_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with direct select and an automatic
// up/down scan mode that wraps at NUM_OUT, for LED rows and digit strobes.
module onehot_scan_decoder
  import onehot_scan_pkg::*;
#(
  parameter int SEL_W    = 3,
  parameter int NUM_OUT  = 8,
  parameter int STEP_CYC = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               en,
  input  logic               mode,
  input  logic               dir,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] out,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  localparam logic [SEL_W:0]   NUM_OUT_EXT = (SEL_W + 1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] IDX_LAST    = SEL_W'(NUM_OUT - 1);

  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               wrap_q, wrap_d;
  logic               step_tick;
  logic               direct_mode;

  assign direct_mode = (mode == MODE_DIRECT);

  onehot_step_tick #(
    .STEP_CYC(STEP_CYC)
  ) u_step_tick (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .en     (en),
    .clr    (direct_mode),
    .tick   (step_tick)
  );

  // Explicit compare-and-wrap keeps non-power-of-two NUM_OUT in range.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (direct_mode) begin
      idx_d = ({1'b0, sel} < NUM_OUT_EXT) ? sel : '0;
    end else if (step_tick) begin
      if (dir == DIR_UP) begin
        if (idx_q == IDX_LAST) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + SEL_W'(1);
        end
      end else begin
        if (idx_q == '0) begin
          idx_d  = IDX_LAST;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q - SEL_W'(1);
        end
      end
    end
    out_d = NUM_OUT'(1) << idx_d;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx_q  <= '0;
      out_q  <= NUM_OUT'(1);
      wrap_q <= 1'b0;
    end else if (en) begin
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed self-checking bench: default, 6-output and 6-output/1-cycle-step
// decoders share the clock and reset but have independent controls.
module tb_onehot_scan_decoder;

  logic clk;
  logic rst;

  logic       aEn, aMode, aDir;
  logic [2:0] aSel, aIdx;
  logic [7:0] aOut;
  logic       aWrap;

  logic       bEn, bMode, bDir;
  logic [2:0] bSel, bIdx;
  logic [5:0] bOut;
  logic       bWrap;

  logic       cEn, cMode, cDir;
  logic [2:0] cSel, cIdx;
  logic [5:0] cOut;
  logic       cWrap;

  int numChecks = 0;
  int numFails  = 0;

  onehot_scan_decoder #(.SEL_W(3), .NUM_OUT(8), .STEP_CYC(4)) dutA (
    .sys_clk(clk), .sys_rst(rst), .en(aEn), .mode(aMode), .dir(aDir),
    .sel(aSel), .out(aOut), .idx(aIdx), .wrap(aWrap)
  );

  onehot_scan_decoder #(.SEL_W(3), .NUM_OUT(6), .STEP_CYC(4)) dutB (
    .sys_clk(clk), .sys_rst(rst), .en(bEn), .mode(bMode), .dir(bDir),
    .sel(bSel), .out(bOut), .idx(bIdx), .wrap(bWrap)
  );

  onehot_scan_decoder #(.SEL_W(3), .NUM_OUT(6), .STEP_CYC(1)) dutC (
    .sys_clk(clk), .sys_rst(rst), .en(cEn), .mode(cMode), .dir(cDir),
    .sel(cSel), .out(cOut), .idx(cIdx), .wrap(cWrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance a number of clock edges, leaving time 1 unit past the last edge.
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    assert (observed === expected)
    else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    aEn = 1'b0; aMode = 1'b0; aDir = 1'b0; aSel = 3'd0;
    bEn = 1'b0; bMode = 1'b0; bDir = 1'b0; bSel = 3'd0;
    cEn = 1'b0; cMode = 1'b0; cDir = 1'b0; cSel = 3'd0;
    applyStimulus(2);
    checkOutput("rst_out", 32'(aOut), 32'h01);
    checkOutput("rst_idx", 32'(aIdx), 32'd0);
    checkOutput("rst_wrap", 32'(aWrap), 32'd0);
    checkOutput("rst_outB", 32'(bOut), 32'h01);
    rst = 1'b0;

    // Direct decode of sel=5, one cycle latency
    aEn = 1'b1; aMode = 1'b0; aSel = 3'd5;
    checkOutput("t1_pre_out", 32'(aOut), 32'h01);
    applyStimulus(1);
    checkOutput("t1_out", 32'(aOut), 32'h20);
    checkOutput("t1_idx", 32'(aIdx), 32'd5);
    checkOutput("t1_wrap", 32'(aWrap), 32'd0);

    // Out-of-range select falls back to bit 0 on a 6-output decoder
    bEn = 1'b1; bMode = 1'b0; bSel = 3'd7;
    applyStimulus(1);
    checkOutput("t2_oor_out", 32'(bOut), 32'h01);
    checkOutput("t2_oor_idx", 32'(bIdx), 32'd0);
    bSel = 3'd5;
    applyStimulus(1);
    checkOutput("t2_top_out", 32'(bOut), 32'h20);
    checkOutput("t2_top_idx", 32'(bIdx), 32'd5);

    // Scan up from idx 6 with a 4-cycle step, wrapping 7 -> 0
    aSel = 3'd6;
    applyStimulus(1);
    checkOutput("t3_load_idx", 32'(aIdx), 32'd6);
    aMode = 1'b1; aDir = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_hold6_out", 32'(aOut), 32'h40);
      checkOutput("t3_hold6_wrap", 32'(aWrap), 32'd0);
      applyStimulus(1);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_hold7_out", 32'(aOut), 32'h80);
      checkOutput("t3_hold7_wrap", 32'(aWrap), 32'd0);
      applyStimulus(1);
    end
    checkOutput("t3_wrap_out", 32'(aOut), 32'h01);
    checkOutput("t3_wrap_pulse", 32'(aWrap), 32'd1);
    applyStimulus(1);
    checkOutput("t3_after_out", 32'(aOut), 32'h01);
    checkOutput("t3_after_wrap", 32'(aWrap), 32'd0);

    // Scan down every cycle on 6 outputs, wrapping 0 -> 5
    cEn = 1'b1; cMode = 1'b0; cSel = 3'd0;
    applyStimulus(1);
    checkOutput("t4_load_idx", 32'(cIdx), 32'd0);
    cMode = 1'b1; cDir = 1'b1;
    applyStimulus(1);
    checkOutput("t4_wrap_idx", 32'(cIdx), 32'd5);
    checkOutput("t4_wrap_out", 32'(cOut), 32'h20);
    checkOutput("t4_wrap_pulse", 32'(cWrap), 32'd1);
    applyStimulus(1);
    checkOutput("t4_next_idx", 32'(cIdx), 32'd4);
    checkOutput("t4_next_out", 32'(cOut), 32'h10);
    checkOutput("t4_next_wrap", 32'(cWrap), 32'd0);
    cEn = 1'b0;

    // en low freezes a partial step; it resumes where it left off
    aMode = 1'b0; aSel = 3'd3;
    applyStimulus(1);
    checkOutput("t5_load_idx", 32'(aIdx), 32'd3);
    aMode = 1'b1; aDir = 1'b0;
    applyStimulus(2);
    aEn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      checkOutput("t5_freeze_out", 32'(aOut), 32'h08);
      checkOutput("t5_freeze_wrap", 32'(aWrap), 32'd0);
    end
    aEn = 1'b1;
    applyStimulus(1);
    checkOutput("t5_resume1_idx", 32'(aIdx), 32'd3);
    applyStimulus(1);
    checkOutput("t5_resume2_idx", 32'(aIdx), 32'd4);
    checkOutput("t5_resume2_out", 32'(aOut), 32'h10);

    // Mid-count reset while scanning, then a full fresh step
    applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    checkOutput("t6_rst_out", 32'(aOut), 32'h01);
    checkOutput("t6_rst_idx", 32'(aIdx), 32'd0);
    checkOutput("t6_rst_wrap", 32'(aWrap), 32'd0);
    rst = 1'b0;
    applyStimulus(3);
    checkOutput("t6_hold_idx", 32'(aIdx), 32'd0);
    applyStimulus(1);
    checkOutput("t6_adv_idx", 32'(aIdx), 32'd1);
    checkOutput("t6_adv_out", 32'(aOut), 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
Parametrised, registered binary-to-one-hot decoder. It is the next generation of the team's 3-to-8 decoder, with a configurable select width and output count. Direct mode decodes an external select. Scan mode steps the active output automatically at a programmable rate, up or down, with wrap-around. It drives LED rows, digit enables and channel strobes in lab designs.

Parameters:
SEL_W, 3, select/index width in bits; legal range >= 1.
NUM_OUT, 8, number of one-hot outputs; legal range 2 <= NUM_OUT <= 2**SEL_W.
STEP_CYC, 4, enabled clock cycles per scan step; legal range >= 1.

Ports:
sys_clk  in  1  system clock; all logic on rising edge.
sys_rst  in  1  synchronous, active-high reset.
en  in  1  clock enable; when low, all state holds.
mode  in  1  0 = direct decode, 1 = auto scan.
dir  in  1  scan direction: 0 = up (idx+1), 1 = down (idx-1).
sel  in  SEL_W  binary select; used in direct mode only.
out  out  NUM_OUT  registered one-hot output; out == 1 << idx at all times.
idx  out  SEL_W  registered binary index of the active output.
wrap  out  1  one-cycle pulse on the cycle that idx wraps in scan mode.

Behaviour:
- Interface: one clock, sys_clk. Reset sys_rst is synchronous and active-high, with priority over en and all other inputs.
- Reset values:
  - out = 1 (bit 0 set).
  - idx = 0.
  - wrap = 0.
  - Internal step counter = 0.
- en = 0:
  - out, idx and the step counter hold.
  - wrap = 0.
- Direct mode (mode = 0, en = 1):
  - If sel < NUM_OUT, idx <= sel; otherwise idx <= 0 (the out-of-range default is bit 0).
  - out <= 1 << next idx.
  - Latency is 1 cycle from sel to out.
  - Step counter is cleared to 0.
  - wrap = 0.
- Scan mode (mode = 1, en = 1):
  - Step counter counts 0 .. STEP_CYC-1.
  - When the counter == STEP_CYC-1: counter <= 0 and idx advances one position in direction dir. Otherwise the counter increments and idx holds.
  - Up wrap: idx == NUM_OUT-1 goes to 0, and wrap = 1 in the cycle the new idx appears.
  - Down wrap: idx == 0 goes to NUM_OUT-1, and wrap = 1 in the same way.
  - With STEP_CYC = 1, idx advances every enabled cycle.
- Mode switch direct to scan: scanning starts from the current idx with the counter at 0. The first advance occurs on the STEP_CYC-th enabled cycle.
- Mode switch scan to direct: takes effect on the next enabled edge and discards any partial step count.
- A dir change takes effect on the next step; the counter is not reset.
- Invariant: out is always exactly one-hot and equals 1 << idx, including after reset and every mode or dir change. Bits at and above NUM_OUT are never set.
- Widths:
  - Step counter width CNT_W = max(1, $clog2(STEP_CYC)).
  - idx arithmetic is explicit compare-and-wrap, never modulo 2**SEL_W, so NUM_OUT values that are not a power of two wrap correctly.

Decomposition:
- Package onehot_scan_pkg holds:
  - MODE_DIRECT = 1'b0 and MODE_SCAN = 1'b1.
  - DIR_UP = 1'b0 and DIR_DOWN = 1'b1.
- One sub-module, onehot_step_tick: the STEP_CYC prescaler.
  - Inputs: sys_clk, sys_rst, en, clr.
  - Output: a tick that is high in the cycle the counter == STEP_CYC-1 with en = 1.
  - The top level asserts clr in direct mode.
- The decode and index logic stays in the top level.

Test Plan:
1. Defaults. Release reset, then mode = 0, en = 1, sel = 3'b101 -> one cycle later out = 8'b0010_0000, idx = 5, wrap = 0. Before that edge, out = 8'b0000_0001.
2. NUM_OUT = 6, SEL_W = 3, direct mode, sel = 3'b111 -> out = 6'b000001, idx = 0. Then sel = 3'b101 -> out = 6'b100000.
3. Defaults, scan up from idx = 6 -> out = 8'b0100_0000 for 4 cycles, then 8'b1000_0000 for 4 cycles, then 8'b0000_0001 with wrap = 1 for exactly one cycle.
4. NUM_OUT = 6, STEP_CYC = 1, scan down from idx = 0 -> next cycle idx = 5, out = 6'b100000, wrap = 1; the following cycle idx = 4, wrap = 0.
5. Scan up with en dropped for 10 cycles after 2 counts at idx = 3 -> out stays 8'b0000_1000 and wrap stays 0. After en returns, idx = 4 on the 2nd enabled cycle.
6. Scan at idx = 4 with mid-count sys_rst = 1 for one cycle while en = 1 -> next edge out = 8'b0000_0001, idx = 0, wrap = 0. The first advance after reset occurs 4 enabled cycles later.
